sram_bus_ctrl: RTL
==================

# sram_bus_ctrl

Memory-side responder for the openmips instruction-fetch and data ports, sharing the single base SRAM between them. It arbitrates the two request ports, sequences the asynchronous SRAM pins (address/CE/OE/WE/byte enables, tri-state data), and returns read data to the core. While an access is outstanding it holds the pipeline with `stall_req_o`. It replaces direct pin wiring at the top level, so the core never sees SRAM timing.

## Interface
- `WAIT_CYCLES`, 1, number of ACCESS cycles per SRAM access; legal range 1–15.
- `clk` in 1, core clock; all logic on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `if_ce_i` in 1, fetch request, held by core while stalled.
- `if_addr_i` in 32, fetch byte address.
- `if_data_o` out 32, fetched instruction.
- `mem_ce_i` in 1, data request, held by core while stalled.
- `mem_we_i` in 1, 1 = write, 0 = read.
- `mem_addr_i` in 32, data byte address.
- `mem_sel_i` in 4, byte lane select; bit n = byte lane n.
- `mem_data_i` in 32, write data.
- `mem_data_o` out 32, read data.
- `stall_req_o` out 1, pipeline stall request.
- `sram_data` inout 32, SRAM data bus.
- `sram_addr` out 20, SRAM word address = selected `addr[21:2]`.
- `sram_be_n` out 4, active-low byte enables.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each, active-low SRAM strobes.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: if a data request is pending and not done, start it. Otherwise, if a fetch request is pending and not done, start it. Otherwise stay.
- SETUP, 1 cycle: `sram_addr`/`sram_be_n` valid and `sram_ce_n`=0. Read: `sram_oe_n`=0 and `sram_be_n`=4'h0. Write: `sram_oe_n`=1, `sram_data` driven with `mem_data_i`, `sram_be_n`=~`mem_sel_i`.
- ACCESS, `WAIT_CYCLES` cycles: same as SETUP. For writes `sram_we_n`=0 in ACCESS only.
- Edge leaving the last ACCESS cycle:
  - read: capture `sram_data` into `if_data_o` or `mem_data_o`;
  - either direction: set that port's done flag.
- DONE, 1 cycle: all strobes high, `sram_data` = Z. Next state is SETUP if the other port is still pending and not done, else IDLE.
- Done flags (`if_done`, `mem_done`) clear on any edge where `stall_req_o`=0, so the core has advanced.
- Stall logic is combinational: `stall_req_o` = (`mem_ce_i` & ~`mem_done`) | (`if_ce_i` & ~`if_done`). It is forced to 0 while `rst`=1.
- Simultaneous fetch and data requests: data is served first, then fetch. Stall holds until both are done.
- `if_data_o` and `mem_data_o` hold their last captured value until overwritten.
- `sram_data` is driven only during SETUP/ACCESS of a write; it is Z otherwise.

## Timing
- Reset values: `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=4'hF, `sram_addr`=0, `sram_data`=Z, `if_data_o`=`mem_data_o`=0. State is IDLE and both done flags are 0.
- Single access requested in cycle 0: `stall_req_o`=1 for cycles 0..1+`WAIT_CYCLES`, then 0 in cycle 2+`WAIT_CYCLES` (DONE). Read data is valid from that cycle.
- With `WAIT_CYCLES`=1: 3 stall cycles.
- Back-to-back data + fetch: the second access enters SETUP right after DONE of the first, with no IDLE cycle between them.
- Reset mid-operation: the next edge forces IDLE and reset values; `sram_we_n` returns high and no partial write strobe is extended.
- Requests withdrawn while in SETUP/ACCESS: the access completes anyway. Its done flag is then ignored because the ce input is low.

## Configuration
- `SRAM_FETCH_BUF_EN` defined: adds a one-entry fetch buffer (valid bit, 20-bit word tag, 32-bit data).
  - Fill: on every fetch capture.
  - Invalidate: on reset, and on completion of a write whose word address equals the tag.
  - Hit: state IDLE, `if_ce_i`=1, no pending data request, valid and tag match. On a hit `if_data_o` returns buffer data combinationally and `stall_req_o` for fetch is 0 in the same cycle, with no SRAM access.
- Not defined: every fetch performs a full SRAM access; no buffer logic.

## Test plan
- Read, `WAIT_CYCLES`=1: SRAM model holds 0xDEADBEEF at word 0x00010, `mem_ce_i`=1, `mem_we_i`=0, `mem_addr_i`=0x00000040 -> `sram_addr`=0x00010, stall high 3 cycles, `mem_data_o`=0xDEADBEEF in cycle 3.
- Byte write: `mem_sel_i`=4'b0010, `mem_data_i`=0x0000AB00, addr 0x80 -> `sram_be_n`=4'b1101, `sram_we_n` low exactly 1 cycle, and the model word changes only in byte 1.
- Simultaneous `if_ce_i` (addr 0x0) and `mem_ce_i` read (addr 0x100) -> data access first, then fetch; `stall_req_o` high 6 cycles, both outputs correct.
- Assert `rst` during ACCESS of a write -> next cycle all strobes high, `sram_data`=Z, both data outputs 0.
- With `SRAM_FETCH_BUF_EN`: fetch 0x4 twice -> second fetch has zero stall cycles. Then write addr 0x4 and fetch 0x4 -> 3 stall cycles and the new data is returned.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// rtl/sram_bus_ctrl.sv - shared base-SRAM responder for the core's fetch and data ports
//
// Arbitrates the instruction-fetch (if_*) and data (mem_*) request ports onto a
// single asynchronous SRAM. Each access walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES
// cycles) -> DONE. Data requests win over fetch requests; a pending second
// request is started straight from DONE without passing through IDLE.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   if_ce_i         fetch request (held by the core while stalled)
//   if_addr_i       fetch byte address
//   if_data_o       last fetched instruction
//   mem_ce_i        data request (held by the core while stalled)
//   mem_we_i        data direction, 1 = write
//   mem_addr_i      data byte address
//   mem_sel_i       byte lane selects for writes
//   mem_data_i      write data
//   mem_data_o      last read data
//   stall_req_o     combinational pipeline hold while any request is unserved
//   sram_data       tri-state SRAM data bus, driven only during a write
//   sram_addr       SRAM word address (byte address bits 21:2)
//   sram_be_n       active-low byte enables
//   sram_ce_n, sram_oe_n, sram_we_n  active-low SRAM strobes
//
// Optional build macro SRAM_FETCH_BUF_EN adds a one-entry fetch buffer that
// answers repeated fetches of the same word without touching the SRAM.

module sram_bus_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    inout  wire  [31:0] sram_data,
    output logic [19:0] sram_addr,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      state;
    logic        if_done;
    logic        mem_done;
    logic        cur_mem;
    logic        cur_we;
    logic [3:0]  wait_cnt;
    logic [31:0] wr_data;
    logic        data_oe;
    logic [31:0] if_data_q;

    logic        fb_hit;
    logic        mem_pend;
    logic        if_pend;
    logic [19:0] sel_addr;
    logic        sel_we;

    // Only the word address within the 4 MB SRAM window is used.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                                mem_addr_i[31:22], mem_addr_i[1:0]};

    // A port is pending while it requests and has not yet been served in
    // this stall episode. A fetch buffer hit serves the fetch without SRAM.
    assign mem_pend = mem_ce_i & ~mem_done;
    assign if_pend  = if_ce_i & ~if_done & ~fb_hit;

    // Data port has priority whenever it is pending.
    assign sel_addr = mem_pend ? mem_addr_i[21:2] : if_addr_i[21:2];
    assign sel_we   = mem_pend & mem_we_i;

    assign stall_req_o = ~rst & (mem_pend | if_pend);

    assign sram_data = data_oe ? wr_data : 32'hzzzz_zzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            cur_mem    <= 1'b0;
            cur_we     <= 1'b0;
            wait_cnt   <= 4'd0;
            wr_data    <= 32'h0;
            data_oe    <= 1'b0;
            if_data_q  <= 32'h0;
            mem_data_o <= 32'h0;
            sram_addr  <= 20'h0;
            sram_be_n  <= 4'hF;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            // Once the core is no longer stalled it has consumed the results.
            if (!stall_req_o) begin
                if_done  <= 1'b0;
                mem_done <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (mem_pend | if_pend) begin
                        state     <= ST_SETUP;
                        cur_mem   <= mem_pend;
                        cur_we    <= sel_we;
                        sram_addr <= sel_addr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= sel_we;
                        sram_be_n <= sel_we ? ~mem_sel_i : 4'h0;
                        wr_data   <= mem_data_i;
                        data_oe   <= sel_we;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    wait_cnt  <= 4'(WAIT_CYCLES - 1);
                    sram_we_n <= ~cur_we;
                end

                ST_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DONE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_be_n <= 4'hF;
                        data_oe   <= 1'b0;
                        // The access completes even if its request was withdrawn.
                        if (cur_mem) begin
                            mem_done <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                        end
                        if (!cur_we) begin
                            if (cur_mem) begin
                                mem_data_o <= sram_data;
                            end else begin
                                if_data_q <= sram_data;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SRAM_FETCH_BUF_EN
    logic        fb_valid;
    logic [19:0] fb_tag;
    logic [31:0] fb_data;
    logic        access_last;

    assign access_last = (state == ST_ACCESS) && (wait_cnt == 4'd0);

    // Hit only from IDLE and only when the data port does not need the SRAM.
    assign fb_hit = (state == ST_IDLE) & if_ce_i & ~mem_pend & fb_valid
                  & (fb_tag == if_addr_i[21:2]);

    assign if_data_o = fb_hit ? fb_data : if_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_valid <= 1'b0;
            fb_tag   <= 20'h0;
            fb_data  <= 32'h0;
        end else if (access_last) begin
            if (!cur_we && !cur_mem) begin
                fb_valid <= 1'b1;
                fb_tag   <= sram_addr;
                fb_data  <= sram_data;
            end else if (cur_we && (sram_addr == fb_tag)) begin
                fb_valid <= 1'b0;
            end
        end
    end
`else
    assign fb_hit    = 1'b0;
    assign if_data_o = if_data_q;
`endif

endmodule
